// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory controller: access sizes, FSM states,
// byte-enable and alignment masks. DMEM_MISALIGN_ERR_EN is consumed by data_memory_ctrl.
package dmem_pkg;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam int MAX_RD_LAT = 4;

  // Byte-lane mask for an 8-lane word; narrower words take the low lanes.
  function automatic logic [7:0] byte_en(input size_e size, input logic [2:0] offset);
    case (size)
      SZ_B:    byte_en = 8'h01 << offset;
      SZ_H:    byte_en = 8'h03 << offset;
      SZ_W:    byte_en = 8'h0F << offset;
      default: byte_en = 8'hFF;
    endcase
  endfunction

  // Offset bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] align_mask(input size_e size);
    case (size)
      SZ_B:    align_mask = 3'b000;
      SZ_H:    align_mask = 3'b001;
      SZ_W:    align_mask = 3'b011;
      default: align_mask = 3'b111;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store-data replication, byte enables, and load
// extract with sign/zero extension. Zero latency, no handshake.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W/8)
) (
  input  size_e               i_size,
  input  logic                i_unsigned,
  input  logic [OFF_W-1:0]    i_off,
  input  logic [DATA_W-1:0]   i_wdata,
  input  logic [DATA_W-1:0]   i_rword,
  output logic [DATA_W-1:0]   o_wdata,
  output logic [DATA_W/8-1:0] o_be,
  output logic [DATA_W-1:0]   o_rdata
);

  localparam int NB = DATA_W/8;

  logic [7:0]        w_be8;
  logic [DATA_W-1:0] w_shift;
  logic [63:0]       w_mask64;
  logic [DATA_W-1:0] w_mask;
  logic [DATA_W-1:0] w_top;
  logic              w_sign;

  assign w_be8 = byte_en(i_size, 3'(i_off));
  assign o_be  = w_be8[NB-1:0];

  always_comb begin
    o_wdata = i_wdata;
    for (int b = 0; b < NB; b++) begin
      case (i_size)
        SZ_B:    o_wdata[8*b +: 8] = i_wdata[7:0];
        SZ_H:    o_wdata[8*b +: 8] = i_wdata[8*(b%2) +: 8];
        SZ_W:    o_wdata[8*b +: 8] = i_wdata[8*(b%4) +: 8];
        default: o_wdata[8*b +: 8] = i_wdata[8*b +: 8];
      endcase
    end
  end

  always_comb begin
    w_mask64 = '1;
    case (i_size)
      SZ_B:    w_mask64 = 64'h0000_0000_0000_00FF;
      SZ_H:    w_mask64 = 64'h0000_0000_0000_FFFF;
      SZ_W:    w_mask64 = 64'h0000_0000_FFFF_FFFF;
      default: w_mask64 = '1;
    endcase
  end

  // The top set bit of the lane mask marks the access MSB used for sign extension.
  assign w_shift = i_rword >> {i_off, 3'b000};
  assign w_mask  = w_mask64[DATA_W-1:0];
  assign w_top   = w_mask & ~(w_mask >> 1);
  assign w_sign  = ~i_unsigned & (|(w_shift & w_top));
  assign o_rdata = (w_shift & w_mask) | ({DATA_W{w_sign}} & ~w_mask);

endmodule

// File: rtl/data_memory_ctrl.sv
// Data memory with req/rsp handshake; load response RD_LAT cycles after accept, store after 1.
// Busy (WAIT/RESP) drops req_ready and ignores requests. Option: DMEM_MISALIGN_ERR_EN.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32,
  parameter int RD_LAT     = 1
) (
  input  logic                                     i_clk,
  input  logic                                     i_reset,
  input  logic                                     i_req_valid,
  output logic                                     o_req_ready,
  input  logic                                     i_req_we,
  input  logic [1:0]                               i_req_size,
  input  logic                                     i_req_unsigned,
  input  logic [DM_ADDRESS+$clog2(DATA_W/8)-1:0]   i_req_addr,
  input  logic [DATA_W-1:0]                        i_req_wdata,
  output logic                                     o_rsp_valid,
  output logic [DATA_W-1:0]                        o_rsp_rdata,
  output logic                                     o_rsp_err
);

  localparam int OFF_W = $clog2(DATA_W/8);
  localparam int AW    = DM_ADDRESS + OFF_W;
  localparam int NB    = DATA_W/8;
  localparam int CNT_W = $clog2(MAX_RD_LAT);

  state_e            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_mem [0:(1<<DM_ADDRESS)-1];
  logic [DATA_W-1:0] r_pipe, r_rsp_rdata;
  logic              r_pipe_err, r_rsp_err;

  size_e             w_size;
  logic              w_accept, w_illegal, w_misalign, w_err, w_wr;
  logic [DM_ADDRESS-1:0] w_idx;
  logic [OFF_W-1:0]  w_off_raw, w_off, w_amask;
  logic [2:0]        w_amask3;
  logic [DATA_W-1:0] w_rword, w_wdata, w_load, w_result;
  logic [NB-1:0]     w_be;

  assign w_size    = size_e'(i_req_size);
  assign w_accept  = i_req_valid && (r_state == IDLE);
  assign w_idx     = i_req_addr[AW-1:OFF_W];
  assign w_off_raw = i_req_addr[OFF_W-1:0];
  assign w_amask3  = align_mask(w_size);
  assign w_amask   = w_amask3[OFF_W-1:0];
  assign w_illegal = (w_size == SZ_D) && (DATA_W == 32);

`ifdef DMEM_MISALIGN_ERR_EN
  assign w_misalign = |(w_off_raw & w_amask);
  assign w_off      = w_off_raw;
`else
  assign w_misalign = 1'b0;
  assign w_off      = w_off_raw & ~w_amask;
`endif

  assign w_err    = w_illegal | w_misalign;
  assign w_rword  = r_mem[w_idx];
  assign w_result = (i_req_we || w_err) ? '0 : w_load;
  assign w_wr     = w_accept && i_req_we && !w_err && !i_reset;

  dmem_lane_align #(.DATA_W(DATA_W), .OFF_W(OFF_W)) u_align (
    .i_size     (w_size),
    .i_unsigned (i_req_unsigned),
    .i_off      (w_off),
    .i_wdata    (i_req_wdata),
    .i_rword    (w_rword),
    .o_wdata    (w_wdata),
    .o_be       (w_be),
    .o_rdata    (w_load)
  );

  always_ff @(posedge i_clk) begin
    if (w_wr) begin
      for (int b = 0; b < NB; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    o_req_ready = 1'b0;
    o_rsp_valid = 1'b0;
    case (r_state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) w_next = (i_req_we || RD_LAT == 1) ? RESP : WAIT;
      end
      WAIT: if (r_cnt == '0) w_next = RESP;
      RESP: begin
        o_rsp_valid = 1'b1;
        w_next      = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Load data is extracted at accept and parked in r_pipe until the response cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_cnt       <= '0;
      r_pipe      <= '0;
      r_pipe_err  <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_pipe     <= w_result;
          r_pipe_err <= w_err;
          if (w_next == WAIT) r_cnt <= CNT_W'(RD_LAT - 2);
          if (w_next == RESP) begin
            r_rsp_rdata <= w_result;
            r_rsp_err   <= w_err;
          end
        end
        WAIT: begin
          if (r_cnt == '0) begin
            r_rsp_rdata <= r_pipe;
            r_rsp_err   <= r_pipe_err;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_rsp_rdata = r_rsp_rdata;
  assign o_rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Randomized bench for data_memory_ctrl against a byte-array reference model.
module tb_data_memory_ctrl;

  localparam int DMA = 9;
  localparam int DW  = 32;
  localparam int RDL = 3;
  localparam int AW  = DMA + 2;

  logic          i_clk = 1'b0;
  logic          i_reset;
  logic          i_req_valid;
  logic          o_req_ready;
  logic          i_req_we;
  logic [1:0]    i_req_size;
  logic          i_req_unsigned;
  logic [AW-1:0] i_req_addr;
  logic [DW-1:0] i_req_wdata;
  logic          o_rsp_valid;
  logic [DW-1:0] o_rsp_rdata;
  logic          o_rsp_err;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] mdl [0:63];

  data_memory_ctrl #(.DM_ADDRESS(DMA), .DATA_W(DW), .RD_LAT(RDL)) dut (
    .i_clk          (i_clk),
    .i_reset        (i_reset),
    .i_req_valid    (i_req_valid),
    .o_req_ready    (o_req_ready),
    .i_req_we       (i_req_we),
    .i_req_size     (i_req_size),
    .i_req_unsigned (i_req_unsigned),
    .i_req_addr     (i_req_addr),
    .i_req_wdata    (i_req_wdata),
    .o_rsp_valid    (o_rsp_valid),
    .o_rsp_rdata    (o_rsp_rdata),
    .o_rsp_err      (o_rsp_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic bit m_err(input int sz, input int a);
    bit e;
    e = (sz == 3) && (DW == 32);
`ifdef DMEM_MISALIGN_ERR_EN
    if ((a % (1 << sz)) != 0) e = 1'b1;
`endif
    return e;
  endfunction

  function automatic int m_base(input int sz, input int a);
`ifdef DMEM_MISALIGN_ERR_EN
    return a;
`else
    return a - (a % (1 << sz));
`endif
  endfunction

  function automatic logic [63:0] m_load(input int sz, input bit uns, input int a);
    int n;
    int b;
    logic [63:0] v;
    n = 1 << sz;
    b = m_base(sz, a);
    v = '0;
    for (int i = 0; i < n; i++) v = v | (64'(mdl[b+i]) << (8*i));
    if (!uns && (8*n < DW) && v[8*n-1]) v = v | (64'hFFFF_FFFF_FFFF_FFFF << (8*n));
    return v & ((64'h1 << DW) - 64'h1);
  endfunction

  task automatic m_store(input int sz, input int a, input logic [63:0] wd);
    int b;
    b = m_base(sz, a);
    for (int i = 0; i < (1 << sz); i++) mdl[b+i] = wd[8*i +: 8];
  endtask

  // One request; request inputs stay asserted with junk while busy to prove they are ignored.
  task automatic xfer(input bit we, input int sz, input bit uns, input int addr,
                      input logic [63:0] wd, output logic [63:0] rd, output logic er);
    int waitc, cyc, rdy_bad;
    bit got, exp_er;
    logic [63:0] exp_rd;
    waitc = 0; cyc = 1; rdy_bad = 0; got = 1'b0; rd = '0; er = 1'b0;
    @(negedge i_clk);
    while (!o_req_ready && waitc < 20) begin
      @(negedge i_clk);
      waitc++;
    end
    check("ready_before_req", 64'(o_req_ready), 64'd1);
    exp_er = m_err(sz, addr);
    exp_rd = (we || exp_er) ? 64'd0 : m_load(sz, uns, addr);
    i_req_valid    = 1'b1;
    i_req_we       = we;
    i_req_size     = 2'(sz);
    i_req_unsigned = uns;
    i_req_addr     = AW'(addr);
    i_req_wdata    = wd[DW-1:0];
    if (we && !exp_er) m_store(sz, addr, wd);
    @(negedge i_clk);
    i_req_we    = 1'b1;
    i_req_size  = 2'd2;
    i_req_addr  = AW'($urandom_range(0, 63));
    i_req_wdata = DW'($urandom);
    while (!got && cyc < 12) begin
      if (o_req_ready) rdy_bad++;
      if (o_rsp_valid) begin
        got = 1'b1;
        rd  = 64'(o_rsp_rdata);
        er  = o_rsp_err;
        i_req_valid = 1'b0;
      end else begin
        @(negedge i_clk);
        cyc++;
      end
    end
    i_req_valid = 1'b0;
    check("rsp_seen", 64'(got), 64'd1);
    check("latency", 64'(cyc), we ? 64'd1 : 64'(RDL));
    check("busy_ready_low", 64'(rdy_bad), 64'd0);
    check("rdata", rd, exp_rd);
    check("err", 64'(er), 64'(exp_er));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [63:0] rd;
    logic        er;
    logic [7:0]  b20, b21;
    int          bad;

    i_reset = 1'b1; i_req_valid = 1'b0; i_req_we = 1'b0; i_req_size = 2'd0;
    i_req_unsigned = 1'b0; i_req_addr = '0; i_req_wdata = '0;
    repeat (2) @(negedge i_clk);
    check("rst_ready", 64'(o_req_ready), 64'd1);
    check("rst_valid", 64'(o_rsp_valid), 64'd0);
    check("rst_rdata", 64'(o_rsp_rdata), 64'd0);
    check("rst_err",   64'(o_rsp_err),   64'd0);
    i_reset = 1'b0;

    for (int w = 0; w < 16; w++) xfer(1'b1, 2, 1'b0, 4*w, 64'($urandom), rd, er);

    xfer(1'b1, 2, 1'b0, 'h10, 64'hDEADBEEF, rd, er);
    xfer(1'b0, 2, 1'b0, 'h10, 64'd0, rd, er);
    check("tp_lw_deadbeef", rd, 64'hDEADBEEF);

    xfer(1'b1, 0, 1'b0, 'h13, 64'h80, rd, er);
    xfer(1'b0, 0, 1'b0, 'h13, 64'd0, rd, er);
    check("tp_lb_signed", rd, 64'hFFFF_FF80);
    xfer(1'b0, 0, 1'b1, 'h13, 64'd0, rd, er);
    check("tp_lbu", rd, 64'h80);
    xfer(1'b0, 2, 1'b0, 'h10, 64'd0, rd, er);
    check("tp_lw_merged", rd, 64'h80AD_BEEF);

    b20 = mdl[32]; b21 = mdl[33];
    xfer(1'b1, 1, 1'b0, 'h22, 64'h1234, rd, er);
    xfer(1'b0, 1, 1'b1, 'h22, 64'd0, rd, er);
    check("tp_lhu", rd, 64'h1234);
    xfer(1'b0, 0, 1'b1, 'h20, 64'd0, rd, er);
    check("tp_b20_kept", rd, 64'(b20));
    xfer(1'b0, 0, 1'b1, 'h21, 64'd0, rd, er);
    check("tp_b21_kept", rd, 64'(b21));

    xfer(1'b0, 2, 1'b0, 'h11, 64'd0, rd, er);
`ifdef DMEM_MISALIGN_ERR_EN
    check("tp_mis_rdata", rd, 64'd0);
    check("tp_mis_err", 64'(er), 64'd1);
`else
    check("tp_mis_rdata", rd, 64'h80AD_BEEF);
    check("tp_mis_err", 64'(er), 64'd0);
`endif

    xfer(1'b1, 3, 1'b0, 'h18, 64'h1111_2222_3333_4444, rd, er);
    check("illegal_store_err", 64'(er), 64'd1);
    xfer(1'b0, 2, 1'b0, 'h18, 64'd0, rd, er);

    // Reset during WAIT drops the load response.
    @(negedge i_clk);
    i_req_valid = 1'b1; i_req_we = 1'b0; i_req_size = 2'd2; i_req_addr = AW'('h10);
    @(negedge i_clk);
    i_req_valid = 1'b0;
    check("rst_mid_busy", 64'(o_req_ready), 64'd0);
    i_reset = 1'b1;
    #1;
    check("rst_async_ready", 64'(o_req_ready), 64'd1);
    @(negedge i_clk);
    i_reset = 1'b0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      if (o_rsp_valid || !o_req_ready) bad++;
      @(negedge i_clk);
    end
    check("rst_no_rsp", 64'(bad), 64'd0);
    xfer(1'b0, 2, 1'b0, 'h10, 64'd0, rd, er);
    check("rst_mem_kept", rd, 64'h80AD_BEEF);

    // A store presented while reset is high must not write.
    i_reset = 1'b1; i_req_valid = 1'b1; i_req_we = 1'b1; i_req_size = 2'd2;
    i_req_addr = AW'('h14); i_req_wdata = DW'(32'hCAFE_F00D);
    @(negedge i_clk);
    i_req_valid = 1'b0; i_reset = 1'b0;
    xfer(1'b0, 2, 1'b0, 'h14, 64'd0, rd, er);

    for (int t = 0; t < 160; t++) begin
      xfer(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 63)), {$urandom, $urandom}, rd, er);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
